vortex_axil_ctrl_slave: RTL

// - AXI4-Lite responder for the Vortex control port; the far end of the bridge's m_axi_ctrl_* master.
// - Decodes single-beat register reads and writes into a small control/status register file.
// - Drives the GPU start pulse and DCR write strobes; reports busy/done back over AXI.
// - Sits inside the Vortex wrapper, between the chipset bridge and the GPU core top.

---
 rtl/vortex_ctrl_pkg.sv | 29 ++
 rtl/vortex_axil_wr_join.sv | 81 ++++++++
 rtl/vortex_axil_ctrl_slave.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vortex_ctrl_pkg.sv
// Shared register offsets, AXI response codes and STATUS bit positions for the
// Vortex AXI4-Lite control slave.
package vortex_ctrl_pkg;

   localparam logic [7:0] REG_CTRL     = 8'h00;
   localparam logic [7:0] REG_STATUS   = 8'h04;
   localparam logic [7:0] REG_DCR_ADDR = 8'h08;
   localparam logic [7:0] REG_DCR_DATA = 8'h0C;
   localparam logic [7:0] REG_IER      = 8'h10;
   localparam logic [7:0] REG_ISR      = 8'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/vortex_axil_wr_join.sv
// Joins independently arriving AW and W beats into a single-cycle commit and
// owns the B response handshake.
module vortex_axil_wr_join
   import vortex_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [ADDR_WIDTH-1:0]     awaddr,
   input  logic                      wvalid,
   output logic                      wready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   output logic                      bvalid,
   input  logic                      bready,
   output logic [1:0]                bresp,
   output logic                      commit,
   output logic [ADDR_WIDTH-1:0]     commit_addr,
   output logic [DATA_WIDTH-1:0]     commit_data,
   output logic [DATA_WIDTH/8-1:0]   commit_strb,
   input  logic                      commit_err
);

   logic                    en_q;
   logic                    aw_full_q;
   logic                    w_full_q;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [DATA_WIDTH/8-1:0] w_strb_q;
   logic                    aw_hs;
   logic                    w_hs;

   assign awready = en_q & ~aw_full_q & ~bvalid;
   assign wready  = en_q & ~w_full_q & ~bvalid;
   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid & wready;

   // A beat arriving this cycle counts as held, so the commit lands on the
   // same edge that completes the pair.
   assign commit      = (aw_full_q | aw_hs) & (w_full_q | w_hs);
   assign commit_addr = aw_full_q ? aw_addr_q : awaddr;
   assign commit_data = w_full_q ? w_data_q : wdata;
   assign commit_strb = w_full_q ? w_strb_q : wstrb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q      <= 1'b0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
      end else begin
         en_q <= 1'b1;
         if (commit) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid    <= 1'b1;
            bresp     <= commit_err ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (aw_hs) begin
               aw_full_q <= 1'b1;
               aw_addr_q <= awaddr;
            end
            if (w_hs) begin
               w_full_q <= 1'b1;
               w_data_q <= wdata;
               w_strb_q <= wstrb;
            end
            if (bvalid & bready) bvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/vortex_axil_ctrl_slave.sv
// AXI4-Lite control slave for Vortex: CSR file, start/DCR strobes, read path.
// Define VORTEX_CTRL_IRQ_EN to add the IER/ISR registers and a live irq_o.
module vortex_axil_ctrl_slave
   import vortex_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_axi_ctrl_awvalid,
   output logic                      s_axi_ctrl_awready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_ctrl_awaddr,
   input  logic                      s_axi_ctrl_wvalid,
   output logic                      s_axi_ctrl_wready,
   input  logic [DATA_WIDTH-1:0]     s_axi_ctrl_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_ctrl_wstrb,
   output logic                      s_axi_ctrl_bvalid,
   input  logic                      s_axi_ctrl_bready,
   output logic [1:0]                s_axi_ctrl_bresp,
   input  logic                      s_axi_ctrl_arvalid,
   output logic                      s_axi_ctrl_arready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_ctrl_araddr,
   output logic                      s_axi_ctrl_rvalid,
   input  logic                      s_axi_ctrl_rready,
   output logic [DATA_WIDTH-1:0]     s_axi_ctrl_rdata,
   output logic [1:0]                s_axi_ctrl_rresp,
   output logic                      start_o,
   input  logic                      busy_i,
   input  logic                      done_i,
   output logic                      dcr_wr_valid_o,
   output logic [DATA_WIDTH-1:0]     dcr_wr_addr_o,
   output logic [DATA_WIDTH-1:0]     dcr_wr_data_o,
   output logic                      irq_o
);

   function automatic logic [ADDR_WIDTH-3:0] word_of(input logic [7:0] off);
      return (ADDR_WIDTH-2)'(off[7:2]);
   endfunction

   function automatic logic is_mapped(input logic [ADDR_WIDTH-3:0] w);
      logic hit;
      hit = (w == word_of(REG_CTRL))     || (w == word_of(REG_STATUS)) ||
            (w == word_of(REG_DCR_ADDR)) || (w == word_of(REG_DCR_DATA));
`ifdef VORTEX_CTRL_IRQ_EN
      hit = hit || (w == word_of(REG_IER)) || (w == word_of(REG_ISR));
`endif
      return hit;
   endfunction

   logic                    commit;
   logic [ADDR_WIDTH-1:0]   commit_addr;
   logic [DATA_WIDTH-1:0]   commit_data;
   logic [DATA_WIDTH/8-1:0] commit_strb;
   logic                    commit_err;
   logic [ADDR_WIDTH-3:0]   cm_word;
   logic [ADDR_WIDTH-3:0]   rd_word;

   vortex_axil_wr_join #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wr_join (
      .clk         (clk),
      .rst         (rst),
      .awvalid     (s_axi_ctrl_awvalid),
      .awready     (s_axi_ctrl_awready),
      .awaddr      (s_axi_ctrl_awaddr),
      .wvalid      (s_axi_ctrl_wvalid),
      .wready      (s_axi_ctrl_wready),
      .wdata       (s_axi_ctrl_wdata),
      .wstrb       (s_axi_ctrl_wstrb),
      .bvalid      (s_axi_ctrl_bvalid),
      .bready      (s_axi_ctrl_bready),
      .bresp       (s_axi_ctrl_bresp),
      .commit      (commit),
      .commit_addr (commit_addr),
      .commit_data (commit_data),
      .commit_strb (commit_strb),
      .commit_err  (commit_err)
   );

   assign cm_word    = commit_addr[ADDR_WIDTH-1:2];
   assign rd_word    = s_axi_ctrl_araddr[ADDR_WIDTH-1:2];
   assign commit_err = ~is_mapped(cm_word);

   logic unused_addr_bits;
   assign unused_addr_bits = ^{commit_addr[1:0], s_axi_ctrl_araddr[1:0]};

   logic                  busy_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] dcr_addr_q;
   logic [DATA_WIDTH-1:0] dcr_data_q;
   logic                  hit_ctrl;
   logic                  hit_dcr_addr;
   logic                  hit_dcr_data;
   logic                  start_set;

   assign hit_ctrl     = commit & (cm_word == word_of(REG_CTRL));
   assign hit_dcr_addr = commit & (cm_word == word_of(REG_DCR_ADDR));
   assign hit_dcr_data = commit & (cm_word == word_of(REG_DCR_DATA));
   assign start_set    = hit_ctrl & commit_strb[0] & commit_data[0];

   assign dcr_wr_addr_o = dcr_addr_q;
   assign dcr_wr_data_o = dcr_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         dcr_addr_q     <= '0;
         dcr_data_q     <= '0;
         start_o        <= 1'b0;
         dcr_wr_valid_o <= 1'b0;
      end else begin
         busy_q         <= busy_i;
         start_o        <= start_set;
         dcr_wr_valid_o <= hit_dcr_data & commit_strb[0];
         // done_i takes priority so a kernel finishing on the start edge is not lost
         if (done_i)         done_q <= 1'b1;
         else if (start_set) done_q <= 1'b0;
         if (hit_dcr_addr) dcr_addr_q <= merge_strb(dcr_addr_q, commit_data, commit_strb);
         if (hit_dcr_data) dcr_data_q <= merge_strb(dcr_data_q, commit_data, commit_strb);
      end
   end

`ifdef VORTEX_CTRL_IRQ_EN
   logic ier_q;
   logic isr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ier_q <= 1'b0;
         isr_q <= 1'b0;
         irq_o <= 1'b0;
      end else begin
         irq_o <= ier_q & isr_q;
         if (commit && cm_word == word_of(REG_IER) && commit_strb[0]) ier_q <= commit_data[0];
         if (done_i)
            isr_q <= 1'b1;
         else if (commit && cm_word == word_of(REG_ISR) && commit_strb[0] && commit_data[0])
            isr_q <= 1'b0;
      end
   end
`else
   assign irq_o = 1'b0;
`endif

   logic                  rd_en_q;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [1:0]            rd_resp;

   assign s_axi_ctrl_arready = rd_en_q & ~s_axi_ctrl_rvalid;

   // Sampled from pre-edge register state, so a colliding write is not visible.
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      if (rd_word == word_of(REG_STATUS)) begin
         rd_data[STATUS_BUSY_BIT] = busy_q;
         rd_data[STATUS_DONE_BIT] = done_q;
      end else if (rd_word == word_of(REG_DCR_ADDR)) begin
         rd_data = dcr_addr_q;
      end else if (rd_word == word_of(REG_DCR_DATA)) begin
         rd_data = dcr_data_q;
`ifdef VORTEX_CTRL_IRQ_EN
      end else if (rd_word == word_of(REG_IER)) begin
         rd_data[0] = ier_q;
      end else if (rd_word == word_of(REG_ISR)) begin
         rd_data[0] = isr_q;
`endif
      end else if (rd_word != word_of(REG_CTRL)) begin
         rd_resp = RESP_SLVERR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q           <= 1'b0;
         s_axi_ctrl_rvalid <= 1'b0;
         s_axi_ctrl_rdata  <= '0;
         s_axi_ctrl_rresp  <= RESP_OKAY;
      end else begin
         rd_en_q <= 1'b1;
         if (s_axi_ctrl_arvalid && s_axi_ctrl_arready) begin
            s_axi_ctrl_rvalid <= 1'b1;
            s_axi_ctrl_rdata  <= rd_data;
            s_axi_ctrl_rresp  <= rd_resp;
         end else if (s_axi_ctrl_rvalid && s_axi_ctrl_rready) begin
            s_axi_ctrl_rvalid <= 1'b0;
         end
      end
   end

endmodule
